mem_stage_mc: RTL and testbench

Parametrised, multi-cycle memory stage for the WiscSP13 pipeline. It resolves the branch target and drives a variable-latency data memory through a request/done handshake. While an access is outstanding it stalls the pipeline. It also selects forwarded store data, and detects misaligned accesses and memory time-outs. It sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_mc.sv | 152 +++++++++++++++
 tb/tb_mem_stage_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: combinational branch resolution, a request/done
// handshake to variable-latency data memory, pipeline stall, misalign and time-out detection.
module mem_stage_mc #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MAX_WAIT    = 64,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC2,
    input  logic [ADDR_W-1:0] imm,
    input  logic              branch,
    input  logic              branch_sel,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] ex_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic              fwd_en,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_done,
    output logic              stall,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_PC,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_valid,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mem_data;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_access;
    logic               w_misalign;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic               w_launch;
    logic               w_rd_done;

    // Branch path is purely combinational; the adder carry-out is dropped.
    assign branch_taken = branch & branch_sel;
    assign branch_PC    = branch_taken ? (PC2 + imm) : PC2;

    assign w_access   = mem_read | mem_write;
    assign w_misalign = (ALIGN_CHECK != 0) && ex_out[0];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_inc == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // dm_done wins over a time-out landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_state_nxt = w_misalign ? S_ERR : S_BUSY;
                end
            end
            S_BUSY: begin
                if (dm_done) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // stall is forced low while reset is held so the pipeline is not frozen by stale inputs.
    always_comb begin
        w_launch  = 1'b0;
        w_rd_done = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = w_access & ~w_misalign;
                stall    = w_access;
            end
            S_BUSY: begin
                w_rd_done = dm_done & ~r_wr;
                stall     = ~dm_done;
            end
            S_ERR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: ;
        endcase
        stall = stall & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_data <= '0;
            r_cnt      <= '0;
        end else if (w_launch) begin
            r_req   <= 1'b1;
            r_wr    <= mem_write;
            r_addr  <= ex_out;
            r_wdata <= fwd_en ? fwd_data : store_data;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            if (dm_done) begin
                r_req <= 1'b0;
                if (!r_wr) begin
                    r_mem_data <= dm_rdata;
                end
            end else if (w_timeout) begin
                r_req <= 1'b0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign dm_req    = r_req;
    assign dm_wr     = r_wr;
    assign dm_addr   = r_addr;
    assign dm_wdata  = r_wdata;
    assign mem_valid = w_rd_done;
    assign mem_data  = w_rd_done ? dm_rdata : r_mem_data;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc with MAX_WAIT=4: branch, load, forwarded store,
// misalign, time-out, dm_done boundary and asynchronous reset cases.
module tb_mem_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] PC2, imm, ex_out, store_data, fwd_data, dm_rdata;
    logic        branch, branch_sel, mem_read, mem_write, fwd_en, dm_done;
    logic        dm_req, dm_wr, stall, branch_taken, mem_valid, err;
    logic [15:0] dm_addr, dm_wdata, branch_PC, mem_data;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(4), .ALIGN_CHECK(1)) dut (
        .clk(clk), .rst(rst), .PC2(PC2), .imm(imm), .branch(branch),
        .branch_sel(branch_sel), .mem_read(mem_read), .mem_write(mem_write),
        .ex_out(ex_out), .store_data(store_data), .fwd_en(fwd_en), .fwd_data(fwd_data),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .stall(stall),
        .branch_taken(branch_taken), .branch_PC(branch_PC), .mem_data(mem_data),
        .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; dm_done = 0; dm_rdata = 16'h0;
        fwd_en = 0; ex_out = 16'h0; store_data = 16'h0; fwd_data = 16'h0;
    endtask

    initial begin
        rst = 0; PC2 = 0; imm = 0; branch = 0; branch_sel = 0;
        idle_inputs();
        mem_read = 1;                       // access present during reset must not stall
        #2;
        check("rst_stall", stall, 0);
        check("rst_dm_req", dm_req, 0);
        check("rst_err", err, 0);
        check("rst_mem_data", mem_data, 16'h0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_dm_addr", dm_addr, 16'h0);
        mem_read = 0;
        next_cycle();
        rst = 1;

        // Branch path
        PC2 = 16'h0010; imm = 16'hFFFC; branch = 1; branch_sel = 1;
        #1;
        check("br_pc_taken", branch_PC, 16'h000C);
        check("br_taken", branch_taken, 1);
        branch_sel = 0;
        #1;
        check("br_pc_not", branch_PC, 16'h0010);
        check("br_taken_not", branch_taken, 0);
        branch = 0;
        check("idle_no_stall", stall, 0);

        // Load, 3-cycle memory
        next_cycle();
        mem_read = 1; ex_out = 16'h0040;
        #2;
        check("ld_c0_stall", stall, 1);
        check("ld_c0_req", dm_req, 0);
        next_cycle(); #1;
        check("ld_c1_req", dm_req, 1);
        check("ld_c1_wr", dm_wr, 0);
        check("ld_c1_addr", dm_addr, 16'h0040);
        check("ld_c1_stall", stall, 1);
        check("ld_c1_valid", mem_valid, 0);
        next_cycle(); #1;
        check("ld_c2_stall", stall, 1);
        next_cycle();
        dm_done = 1; dm_rdata = 16'hBEEF;
        #1;
        check("ld_c3_stall", stall, 0);
        check("ld_c3_valid", mem_valid, 1);
        check("ld_c3_data", mem_data, 16'hBEEF);
        next_cycle();
        idle_inputs();
        #1;
        check("ld_after_req", dm_req, 0);
        check("ld_after_valid", mem_valid, 0);
        check("ld_after_data", mem_data, 16'hBEEF);
        check("ld_after_stall", stall, 0);

        // Store with forwarding; launch values must hold during BUSY
        next_cycle();
        mem_write = 1; ex_out = 16'h0022; store_data = 16'h1111; fwd_en = 1; fwd_data = 16'h2222;
        #1;
        check("st_c0_stall", stall, 1);
        next_cycle(); #1;
        check("st_c1_req", dm_req, 1);
        check("st_c1_wr", dm_wr, 1);
        check("st_c1_addr", dm_addr, 16'h0022);
        check("st_c1_wdata", dm_wdata, 16'h2222);
        check("st_c1_valid", mem_valid, 0);
        fwd_data = 16'h3333; ex_out = 16'h0099; fwd_en = 0;
        next_cycle(); #1;
        check("st_c2_wdata", dm_wdata, 16'h2222);
        check("st_c2_addr", dm_addr, 16'h0022);
        dm_done = 1; dm_rdata = 16'hAAAA;
        #1;
        check("st_done_valid", mem_valid, 0);
        check("st_done_stall", stall, 0);
        check("st_done_data", mem_data, 16'hBEEF);
        next_cycle();
        idle_inputs();
        #1;
        check("st_after_req", dm_req, 0);
        check("st_after_data", mem_data, 16'hBEEF);

        // dm_done outside BUSY is ignored
        dm_done = 1; dm_rdata = 16'h5555;
        #1;
        check("stray_valid", mem_valid, 0);
        check("stray_data", mem_data, 16'hBEEF);
        check("stray_stall", stall, 0);
        next_cycle();
        idle_inputs();

        // dm_done in BUSY cycle 4 (same cycle the counter expires): completion wins
        mem_read = 1; ex_out = 16'h0060;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 4) begin
                dm_done = 1; dm_rdata = 16'h1234;
            end
            #1;
            check($sformatf("lim_c%0d_req", c), dm_req, 1);
        end
        check("lim_c4_stall", stall, 0);
        check("lim_c4_valid", mem_valid, 1);
        next_cycle();
        idle_inputs();
        #1;
        check("lim_err", err, 0);
        check("lim_req", dm_req, 0);
        check("lim_stall", stall, 0);
        check("lim_data", mem_data, 16'h1234);

        // Time-out: no dm_done for 4 BUSY cycles
        mem_read = 1; ex_out = 16'h0070;
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); #1;
            check($sformatf("to_c%0d_req", c), dm_req, 1);
            check($sformatf("to_c%0d_err", c), err, 0);
        end
        next_cycle(); #1;
        check("to_err", err, 1);
        check("to_req", dm_req, 0);
        check("to_stall", stall, 1);
        dm_done = 1; dm_rdata = 16'h7777;
        #1;
        check("to_done_ignored", mem_valid, 0);
        next_cycle(); #1;
        check("to_err_sticky", err, 1);
        idle_inputs();
        rst = 0;
        #1;
        check("to_rst_err", err, 0);
        check("to_rst_stall", stall, 0);
        check("to_rst_data", mem_data, 16'h0);
        next_cycle();
        rst = 1;

        // Misaligned access never raises dm_req
        mem_read = 1; ex_out = 16'h0041;
        #1;
        check("mis_c0_stall", stall, 1);
        check("mis_c0_req", dm_req, 0);
        next_cycle(); #1;
        check("mis_err", err, 1);
        check("mis_req", dm_req, 0);
        check("mis_stall", stall, 1);
        mem_read = 0;
        #1;
        check("mis_stall_hold", stall, 1);
        rst = 0;
        #1;
        rst = 1;
        #1;
        check("mis_rst_err", err, 0);

        // Reset mid-access drops dm_req without a clock edge
        next_cycle();
        mem_read = 1; ex_out = 16'h0080;
        next_cycle(); #1;
        check("ra_c1_req", dm_req, 1);
        next_cycle(); #1;
        check("ra_c2_req", dm_req, 1);
        rst = 0;
        #1;
        check("ra_async_req", dm_req, 0);
        idle_inputs();
        #1;
        rst = 1;
        #1;
        check("ra_stall", stall, 0);
        check("ra_data", mem_data, 16'h0);
        check("ra_err", err, 0);
        next_cycle(); #1;
        check("ra_idle_req", dm_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
